retire_trace_monitor: RTL and testbench
=======================================

Name: retire_trace_monitor

Overview:
- Sits directly downstream of the core's RVFI-style retirement tracer interface and consumes one retirement record per cycle when valid.
- Checks each record against architectural invariants and keeps sticky error flags.
- Buffers compact trace records in a FIFO, read out over a valid/ready port by a bench scoreboard or debug UART.
- Retirement input is never back-pressured. Overflow drops records and counts them.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the drop and retire counters; counters saturate.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rvfi_valid  in  1  a retirement record is present this cycle
- rvfi_order  in  64  retirement sequence number
- rvfi_insn  in  32  retired instruction word
- rvfi_trap  in  1  instruction trapped
- rvfi_halt  in  1  final instruction before halt
- rvfi_rd_addr  in  5  destination register
- rvfi_rd_wdata  in  32  destination write data
- rvfi_pc_rdata  in  32  PC of the retired instruction
- rvfi_pc_wdata  in  32  next PC
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  consumer accepts the head
- out_data  out  102  {trap, rd_wdata, rd_addr, insn, pc_rdata}, pc_rdata in bits [31:0]
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- drop_cnt  out  CNT_W  records dropped on overflow; saturating
- retire_cnt  out  CNT_W  records observed; saturating
- err_flags  out  5  sticky errors: [0] ORDER, [1] X0, [2] MISALIGN, [3] PC_CONT, [4] AFTER_HALT
- err_order  out  64  rvfi_order of the first erroring record
- clr_err  in  1  clears err_flags and err_order
- halted  out  1  monitor is in HALTED

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE. Reset mid-operation discards FIFO contents and counters.
- A record is "taken" when rvfi_valid=1 and state != HALTED.

States:
- IDLE --taken--> RUN. The first record sets expected_order = rvfi_order+1 and prev_pc_wdata = rvfi_pc_wdata. It is not order- or PC-checked.
- RUN --taken--> RUN. Per record: expected_order += 1 and prev_pc_wdata updates.
- IDLE or RUN --taken with rvfi_halt=1--> HALTED. The halting record is still checked and pushed.
- HALTED is left only by rst. Any rvfi_valid in HALTED sets AFTER_HALT, is not pushed, and does not count.

Checks (evaluated on the same cycle the record is taken; flags visible next cycle):
- ORDER: in RUN, rvfi_order != expected_order.
- X0: rvfi_rd_addr == 0 and rvfi_rd_wdata != 0.
- MISALIGN: rvfi_pc_wdata[1:0] != 0 and rvfi_trap == 0.
- PC_CONT: see Optional Feature.

Error capture:
- err_order is captured only when err_flags == 0 before the new error. Later errors OR into err_flags but do not overwrite err_order.
- clr_err takes priority over a simultaneous new error for that cycle. The new error is lost.

FIFO:
- Push on every taken record. Pop when out_valid && out_ready.
- Full with no pop: the record is dropped, drop_cnt += 1. Checks and counters still apply.
- Full with a pop in the same cycle: the push is accepted and level is unchanged.
- Empty: there is no bypass. A pushed record appears on out_valid the next cycle (latency 1).
- out_data is stable while out_valid=1 && out_ready=0.
- retire_cnt increments on every taken record, whether pushed or dropped.
- Pointers wrap modulo DEPTH; level distinguishes full from empty.

Optional Feature:
- Macro: RETIRE_MON_PC_CHECK_EN.
- Defined: PC_CONT (err_flags[3]) is set in RUN when rvfi_pc_rdata != prev_pc_wdata.
- Not defined: err_flags[3] is tied 0, no prev_pc_wdata register is built, and the check is skipped.

Decomposition:
- Package retire_mon_pkg holds:
  - trace_rec_t packed struct (102 bits);
  - mon_state_e enum {IDLE, RUN, HALTED};
  - error bit index localparams ERR_ORDER=0 through ERR_AFTER_HALT=4.
- One sub-module: trace_fifo, a parameterised synchronous FIFO with push/pop, full/empty, level and simultaneous push/pop-when-full accept. The checker, FSM and counters stay in the top module.

Test Plan:
- Retire orders 0..4, sequential PCs 0x0,0x4,... with out_ready=1 -> 5 records out in order, err_flags=0, retire_cnt=5, level returns to 0.
- Orders 0,1,3 -> err_flags=5'b00001, err_order=3. Then clr_err=1 -> err_flags=0.
- rd_addr=0, rd_wdata=0x1234 -> X0 set. pc_wdata=0x102 with trap=0 -> MISALIGN set; the same with trap=1 -> no flag.
- out_ready=0, 20 records with DEPTH=16 -> level=16, drop_cnt=4, retire_cnt=20. The first 16 records drain intact. Also drive a push and pop in the same cycle while full -> accepted, level stays 16.
- Record with rvfi_halt=1, then 2 more valids -> halted=1, AFTER_HALT set, retire_cnt unchanged by the extra valids. rst -> state IDLE, all counters and flags 0.
- With RETIRE_MON_PC_CHECK_EN: record 0 has pc_wdata=0x8, record 1 has pc_rdata=0xC -> PC_CONT set. Without the macro -> err_flags[3]=0.

Source files
------------

// File: rtl/retire_mon_pkg.sv
// Shared types for the retirement trace monitor: the compact trace record,
// the monitor state encoding and the bit positions inside err_flags.
package retire_mon_pkg;

  // Field order fixes the out_data layout; pc_rdata lands in bits [31:0].
  typedef struct packed {
    logic        trap;
    logic [31:0] rd_wdata;
    logic [4:0]  rd_addr;
    logic [31:0] insn;
    logic [31:0] pc_rdata;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } mon_state_e;

  localparam int ERR_ORDER      = 0;
  localparam int ERR_X0         = 1;
  localparam int ERR_MISALIGN   = 2;
  localparam int ERR_PC_CONT    = 3;
  localparam int ERR_AFTER_HALT = 4;
  localparam int ERR_W          = 5;

  localparam int REC_W = $bits(trace_rec_t);

endpackage

// File: rtl/retire_trace_monitor_fifo.sv
// trace_fifo: synchronous FIFO without bypass. A push into a full FIFO is
// accepted when a pop happens in the same cycle; push_ok reports acceptance.
module trace_fifo #(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 102,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             push_ok,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_fire;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign pop_fire = pop && !empty;
  assign push_ok  = push && (!full || pop_fire);
  assign head     = mem[rd_ptr];

  // Storage write port.
  // NOTE: the data array is deliberately not reset; level gates every read, so
  // stale contents are never observed and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at DEPTH (power of two); level tells full from empty.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order across blocks.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_fire})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/retire_trace_monitor.sv
// retire_trace_monitor: checks RVFI retirement records against architectural
// invariants, keeps sticky error flags and buffers compact trace records.
// Optional macro RETIRE_MON_PC_CHECK_EN enables the PC continuity check
// (err_flags[3]); without it that flag is tied 0 and no PC history is kept.
module retire_trace_monitor
  import retire_mon_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rvfi_valid,
  input  logic [63:0]              rvfi_order,
  input  logic [31:0]              rvfi_insn,
  input  logic                     rvfi_trap,
  input  logic                     rvfi_halt,
  input  logic [4:0]               rvfi_rd_addr,
  input  logic [31:0]              rvfi_rd_wdata,
  input  logic [31:0]              rvfi_pc_rdata,
  input  logic [31:0]              rvfi_pc_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REC_W-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         retire_cnt,
  output logic [ERR_W-1:0]         err_flags,
  output logic [63:0]              err_order,
  input  logic                     clr_err,
  output logic                     halted
);

  mon_state_e       state_q, state_d;
  logic             taken;
  logic             push_ok;
  logic             fifo_full;
  logic             fifo_empty;
  logic [63:0]      expected_order;
  logic [ERR_W-1:0] new_err;
  trace_rec_t       rec;

  assign taken     = rvfi_valid && (state_q != HALTED);
  assign halted    = (state_q == HALTED);
  assign out_valid = !fifo_empty;

  assign rec = '{trap:     rvfi_trap,
                 rd_wdata: rvfi_rd_wdata,
                 rd_addr:  rvfi_rd_addr,
                 insn:     rvfi_insn,
                 pc_rdata: rvfi_pc_rdata};

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (taken),
    .push_data (rec),
    .pop       (out_ready),
    .push_ok   (push_ok),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (out_data),
    .level     (level)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: any taken record leaves IDLE; a halting record ends the trace.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: if (taken) state_d = rvfi_halt ? HALTED : RUN;
      default:   state_d = HALTED;
    endcase
  end

  // Sequence tracking: first record seeds, later ones advance by one.
  always_ff @(posedge clk) begin
    if (rst)                             expected_order <= '0;
    else if (taken && state_q == IDLE)   expected_order <= rvfi_order + 64'd1;
    else if (taken)                      expected_order <= expected_order + 64'd1;
  end

`ifdef RETIRE_MON_PC_CHECK_EN
  logic [31:0] prev_pc_wdata;

  // Next-PC history for the continuity check.
  always_ff @(posedge clk) begin
    if (rst)        prev_pc_wdata <= '0;
    else if (taken) prev_pc_wdata <= rvfi_pc_wdata;
  end
`endif

  // Invariant checks on the record presented this cycle.
  always_comb begin
    new_err = '0;
    if (taken) begin
      if (state_q == RUN && rvfi_order != expected_order) new_err[ERR_ORDER]    = 1'b1;
      if (rvfi_rd_addr == 5'd0 && rvfi_rd_wdata != '0)    new_err[ERR_X0]       = 1'b1;
      if (rvfi_pc_wdata[1:0] != 2'b00 && !rvfi_trap)      new_err[ERR_MISALIGN] = 1'b1;
`ifdef RETIRE_MON_PC_CHECK_EN
      if (state_q == RUN && rvfi_pc_rdata != prev_pc_wdata) new_err[ERR_PC_CONT] = 1'b1;
`endif
    end
    if (rvfi_valid && state_q == HALTED) new_err[ERR_AFTER_HALT] = 1'b1;
  end

  // Sticky flags; err_order latches only the first error; clear wins.
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_flags <= '0;
      err_order <= '0;
    end else if (new_err != '0) begin
      if (err_flags == '0) err_order <= rvfi_order;
      err_flags <= err_flags | new_err;
    end
  end

  // Saturating retire and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      if (taken && retire_cnt != '1)             retire_cnt <= retire_cnt + 1'b1;
      if (taken && !push_ok && drop_cnt != '1)   drop_cnt   <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_retire_trace_monitor.sv
// Directed self-checking bench for retire_trace_monitor (DEPTH=16, CNT_W=16).
module tb_retire_trace_monitor;

  logic         clk = 1'b0;
  logic         rst;
  logic         rvfi_valid;
  logic [63:0]  rvfi_order;
  logic [31:0]  rvfi_insn;
  logic         rvfi_trap;
  logic         rvfi_halt;
  logic [4:0]   rvfi_rd_addr;
  logic [31:0]  rvfi_rd_wdata;
  logic [31:0]  rvfi_pc_rdata;
  logic [31:0]  rvfi_pc_wdata;
  logic         out_valid;
  logic         out_ready;
  logic [101:0] out_data;
  logic [4:0]   level;
  logic [15:0]  drop_cnt;
  logic [15:0]  retire_cnt;
  logic [4:0]   err_flags;
  logic [63:0]  err_order;
  logic         clr_err;
  logic         halted;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [101:0] got[$];

  retire_trace_monitor #(.DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .drop_cnt(drop_cnt), .retire_cnt(retire_cnt),
    .err_flags(err_flags), .err_order(err_order), .clr_err(clr_err),
    .halted(halted)
  );

  always #5 clk = ~clk;

  // Capture every record the consumer accepts, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got.push_back(out_data);
  end

  // Expected packing {trap, rd_wdata, rd_addr, insn, pc_rdata}.
  function automatic logic [101:0] mk(input logic trap, input logic [31:0] wd,
                                      input logic [4:0] ra, input logic [31:0] insn,
                                      input logic [31:0] pc);
    return {trap, wd, ra, insn, pc};
  endfunction

  // Canonical well-formed record i: sequential PCs 4*i, rd x3.
  function automatic logic [101:0] rec_of(input int i);
    return mk(1'b0, 32'hA000 + i, 5'd3, 32'h200 + i, 32'(4 * i));
  endfunction

  task automatic do_reset();
    rst = 1'b1; rvfi_valid = 1'b0; clr_err = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got.delete();
  endtask

  task automatic send(input logic [63:0] order, input logic [31:0] insn,
                      input logic trap, input logic halt, input logic [4:0] ra,
                      input logic [31:0] wd, input logic [31:0] pc_r,
                      input logic [31:0] pc_w);
    rvfi_valid = 1'b1; rvfi_order = order; rvfi_insn = insn; rvfi_trap = trap;
    rvfi_halt = halt; rvfi_rd_addr = ra; rvfi_rd_wdata = wd;
    rvfi_pc_rdata = pc_r; rvfi_pc_wdata = pc_w;
    @(posedge clk);
    #1 rvfi_valid = 1'b0; rvfi_halt = 1'b0;
  endtask

  task automatic send_seq(input int i, input logic halt);
    send(64'(i), 32'h200 + i, 1'b0, halt, 5'd3, 32'hA000 + i,
         32'(4 * i), 32'(4 * i + 4));
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({out_valid, level, drop_cnt, retire_cnt, err_flags, err_order, halted} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b level=%0d drop=%0d ret=%0d flags=%b ord=%0d halted=%b, want all 0",
               out_valid, level, drop_cnt, retire_cnt, err_flags, err_order, halted);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_seq(i, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (got.size() != 5) begin
      tests_failed++; $display("FAIL seq_count: got %0d records, want 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (got[i] !== rec_of(i)) begin
          tests_failed++; $display("FAIL seq_rec%0d: got %h want %h", i, got[i], rec_of(i));
        end
      end
    end
    tests_run++;
    if (err_flags !== 5'b0) begin
      tests_failed++; $display("FAIL seq_flags: got %b want 00000", err_flags);
    end
    tests_run++;
    if (retire_cnt !== 16'd5) begin
      tests_failed++; $display("FAIL seq_retire: got %0d want 5", retire_cnt);
    end
    tests_run++;
    if (level !== 5'd0) begin
      tests_failed++; $display("FAIL seq_level: got %0d want 0", level);
    end
  endtask

  task automatic test_order_error();
    do_reset();
    out_ready = 1'b1;
    send_seq(0, 1'b0);
    send_seq(1, 1'b0);
    send(64'd3, 32'h202, 1'b0, 1'b0, 5'd3, 32'hA002, 32'h8, 32'hC);
    tests_run++;
    if (err_flags !== 5'b00001) begin
      tests_failed++; $display("FAIL order_flags: got %b want 00001", err_flags);
    end
    tests_run++;
    if (err_order !== 64'd3) begin
      tests_failed++; $display("FAIL order_capture: got %0d want 3", err_order);
    end
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    tests_run++;
    if (err_flags !== 5'b0 || err_order !== 64'd0) begin
      tests_failed++; $display("FAIL order_clear: got flags=%b ord=%0d want 0/0", err_flags, err_order);
    end
  endtask

  task automatic test_x0_misalign();
    do_reset();
    out_ready = 1'b1;
    send(64'd0, 32'h33, 1'b0, 1'b0, 5'd0, 32'h1234, 32'h0, 32'h4);
    tests_run++;
    if (err_flags !== 5'b00010) begin
      tests_failed++; $display("FAIL x0_flag: got %b want 00010", err_flags);
    end
    clr_err = 1'b1; @(posedge clk); #1 clr_err = 1'b0;
    send(64'd1, 32'h33, 1'b0, 1'b0, 5'd1, 32'h0, 32'h4, 32'h102);
    tests_run++;
    if (err_flags !== 5'b00100 || err_order !== 64'd1) begin
      tests_failed++; $display("FAIL misalign_flag: got flags=%b ord=%0d want 00100/1", err_flags, err_order);
    end
    clr_err = 1'b1; @(posedge clk); #1 clr_err = 1'b0;
    send(64'd2, 32'h33, 1'b1, 1'b0, 5'd1, 32'h0, 32'h102, 32'h102);
    tests_run++;
    if (err_flags !== 5'b00000) begin
      tests_failed++; $display("FAIL misalign_trap: got %b want 00000", err_flags);
    end
    // Clear coinciding with a new X0 error: the clear wins, error lost.
    clr_err = 1'b1;
    send(64'd3, 32'h33, 1'b0, 1'b0, 5'd0, 32'h5, 32'h102, 32'h200);
    clr_err = 1'b0;
    tests_run++;
    if (err_flags !== 5'b00000 || err_order !== 64'd0) begin
      tests_failed++; $display("FAIL clr_priority: got flags=%b ord=%0d want 0/0", err_flags, err_order);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 20; i++) send_seq(i, 1'b0);
    tests_run++;
    if (level !== 5'd16 || drop_cnt !== 16'd4 || retire_cnt !== 16'd20) begin
      tests_failed++;
      $display("FAIL ovf_counts: got level=%0d drop=%0d ret=%0d want 16/4/20", level, drop_cnt, retire_cnt);
    end
    // Push and pop together while full.
    out_ready = 1'b1;
    send_seq(20, 1'b0);
    out_ready = 1'b0;
    tests_run++;
    if (level !== 5'd16 || drop_cnt !== 16'd4 || retire_cnt !== 16'd21) begin
      tests_failed++;
      $display("FAIL full_pushpop: got level=%0d drop=%0d ret=%0d want 16/4/21", level, drop_cnt, retire_cnt);
    end
    // Head must hold while stalled.
    tests_run++;
    if (out_data !== rec_of(1)) begin
      tests_failed++; $display("FAIL stall_head: got %h want %h", out_data, rec_of(1));
    end
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 out_ready = 1'b0;
    tests_run++;
    if (got.size() != 17) begin
      tests_failed++; $display("FAIL drain_count: got %0d records, want 17", got.size());
    end else begin
      for (int i = 0; i < 17; i++) begin
        tests_run++;
        if (got[i] !== rec_of(i < 16 ? i : 20)) begin
          tests_failed++;
          $display("FAIL drain_rec%0d: got %h want %h", i, got[i], rec_of(i < 16 ? i : 20));
        end
      end
    end
    tests_run++;
    if (level !== 5'd0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL drain_empty: got level=%0d valid=%b want 0/0", level, out_valid);
    end
  endtask

  task automatic test_halt();
    do_reset();
    send_seq(0, 1'b0);
    send_seq(1, 1'b1);
    send_seq(2, 1'b0);
    send_seq(3, 1'b0);
    tests_run++;
    if (halted !== 1'b1 || err_flags !== 5'b10000 || err_order !== 64'd2) begin
      tests_failed++;
      $display("FAIL halt_flags: got halted=%b flags=%b ord=%0d want 1/10000/2", halted, err_flags, err_order);
    end
    tests_run++;
    if (retire_cnt !== 16'd2 || level !== 5'd2) begin
      tests_failed++; $display("FAIL halt_counts: got ret=%0d level=%0d want 2/2", retire_cnt, level);
    end
    do_reset();
    tests_run++;
    if ({halted, err_flags, retire_cnt, drop_cnt, level, out_valid} !== '0) begin
      tests_failed++;
      $display("FAIL halt_reset: got halted=%b flags=%b ret=%0d drop=%0d level=%0d want all 0",
               halted, err_flags, retire_cnt, drop_cnt, level);
    end
    // After reset the monitor is back in IDLE and accepts records again.
    send_seq(5, 1'b0);
    tests_run++;
    if (retire_cnt !== 16'd1 || err_flags !== 5'b0) begin
      tests_failed++; $display("FAIL post_reset_take: got ret=%0d flags=%b want 1/00000", retire_cnt, err_flags);
    end
  endtask

  task automatic test_pc_cont();
    logic [4:0] want;
    do_reset();
    out_ready = 1'b1;
    send(64'd0, 32'h13, 1'b0, 1'b0, 5'd1, 32'h0, 32'h0, 32'h8);
    send(64'd1, 32'h13, 1'b0, 1'b0, 5'd1, 32'h0, 32'hC, 32'h10);
`ifdef RETIRE_MON_PC_CHECK_EN
    want = 5'b01000;
`else
    want = 5'b00000;
`endif
    tests_run++;
    if (err_flags !== want) begin
      tests_failed++; $display("FAIL pc_cont: got %b want %b", err_flags, want);
    end
  endtask

  initial begin
    rst = 1'b1; rvfi_valid = 1'b0; rvfi_order = '0; rvfi_insn = '0;
    rvfi_trap = 1'b0; rvfi_halt = 1'b0; rvfi_rd_addr = '0; rvfi_rd_wdata = '0;
    rvfi_pc_rdata = '0; rvfi_pc_wdata = '0; out_ready = 1'b0; clr_err = 1'b0;
    test_reset();
    test_sequential();
    test_order_error();
    test_x0_misalign();
    test_overflow();
    test_halt();
    test_pc_cont();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
